// File: rtl/detect_sched.sv
// detect_sched: two-requester round-robin scheduler that time-shares a single serial
// sequence detector (Moore FSM, input a / output y) in fixed-length frames.
//
// Each granted frame runs: CLEAR (1 cycle) -> STREAM (FRAME_LEN cycles) -> RELEASE (1 cycle).
// During CLEAR the detector is cleared. During STREAM the owner's serial bit is steered
// onto det_a. Detector hits are attributed back to the owner.
//
// Parameters:
//   FRAME_LEN  bits per granted frame (2..255)
//   CW         bit-counter width
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-high reset
//   req0, req1     frame requests, sampled only while idle
//   d0, d1         serial data from requester 0 / 1
//   gnt0, gnt1     one-hot grant (CLEAR and STREAM)
//   shift          owner's current bit is consumed this cycle
//   det_clr        one-cycle detector clear pulse
//   det_a          bit driven to the detector input (0 outside STREAM)
//   y              detector output
//   hit0, hit1     detector hit attributed to requester 0 / 1
//   done           one-cycle end-of-frame pulse
//   busy           high in every state except idle
//   hit_cnt0/1     saturating hit-cycle counters (only with DETECT_SCHED_HITCNT_EN)
//
// Optional feature macro: DETECT_SCHED_HITCNT_EN adds the hit_cnt0/hit_cnt1 outputs.

module detect_sched #(
    parameter int unsigned FRAME_LEN = 8,
    parameter int unsigned CW        = $clog2(FRAME_LEN + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic       d0,
    input  logic       d1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       shift,
    output logic       det_clr,
    output logic       det_a,
    input  logic       y,
    output logic       hit0,
    output logic       hit1,
    output logic       done,
`ifdef DETECT_SCHED_HITCNT_EN
    output logic [7:0] hit_cnt0,
    output logic [7:0] hit_cnt1,
`endif
    output logic       busy
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StClear   = 2'd1,
        StStream  = 2'd2,
        StRelease = 2'd3
    } state_e;

    localparam logic [CW-1:0] LastCnt = CW'(FRAME_LEN - 1);

    state_e        state_q, state_d;
    logic          own_q, own_d;
    logic          prio_q, prio_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Hit window: the detector output lags its input by one cycle, so the
    // response to STREAM bit k appears at STREAM count k+1, and the response
    // to the final bit appears during RELEASE.
    logic hit_win;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            own_q   <= 1'b0;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    // A lone requester wins outright; a tie goes to the favoured one.
                    if (req0 && req1) begin
                        own_d = prio_q;
                    end else begin
                        own_d = req1;
                    end
                    state_d = StClear;
                end
            end
            StClear: begin
                cnt_d   = '0;
                state_d = StStream;
            end
            StStream: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LastCnt) begin
                    state_d = StRelease;
                end
            end
            StRelease: begin
                prio_d  = ~own_q;
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        shift   = 1'b0;
        det_clr = 1'b0;
        det_a   = 1'b0;
        done    = 1'b0;
        hit_win = 1'b0;

        unique case (state_q)
            StIdle: begin
            end
            StClear: begin
                gnt0    = ~own_q;
                gnt1    = own_q;
                det_clr = 1'b1;
            end
            StStream: begin
                gnt0    = ~own_q;
                gnt1    = own_q;
                shift   = 1'b1;
                det_a   = own_q ? d1 : d0;
                hit_win = (cnt_q != '0);
            end
            StRelease: begin
                done    = 1'b1;
                hit_win = 1'b1;
            end
        endcase
    end

    assign hit0 = hit_win & ~own_q & y;
    assign hit1 = hit_win & own_q & y;
    assign busy = (state_q != StIdle);

`ifdef DETECT_SCHED_HITCNT_EN
    // ------------------------------------------------------------------
    // Saturating hit-cycle counters, cleared only by reset
    // ------------------------------------------------------------------
    logic [7:0] hit_cnt0_q, hit_cnt1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt0_q <= 8'd0;
            hit_cnt1_q <= 8'd0;
        end else begin
            if (hit0 && (hit_cnt0_q != 8'hFF)) begin
                hit_cnt0_q <= hit_cnt0_q + 8'd1;
            end
            if (hit1 && (hit_cnt1_q != 8'hFF)) begin
                hit_cnt1_q <= hit_cnt1_q + 8'd1;
            end
        end
    end

    assign hit_cnt0 = hit_cnt0_q;
    assign hit_cnt1 = hit_cnt1_q;
`endif

endmodule

// File: tb/tb_detect_sched.sv
// Directed bench for detect_sched with FRAME_LEN = 8. Inputs change 1 time unit
// after the rising edge; outputs are sampled on the falling edge.

module tb_detect_sched;

    localparam int unsigned FL = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic req0  = 1'b0;
    logic req1  = 1'b0;
    logic d0    = 1'b0;
    logic d1    = 1'b0;
    logic y     = 1'b0;

    logic gnt0, gnt1, shift, det_clr, det_a, hit0, hit1, done, busy;
`ifdef DETECT_SCHED_HITCNT_EN
    logic [7:0] hit_cnt0, hit_cnt1;
`endif

    int n_cmp = 0;
    int n_err = 0;

    detect_sched #(
        .FRAME_LEN (FL)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (req0),
        .req1     (req1),
        .d0       (d0),
        .d1       (d1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .shift    (shift),
        .det_clr  (det_clr),
        .det_a    (det_a),
        .y        (y),
        .hit0     (hit0),
        .hit1     (hit1),
        .done     (done),
`ifdef DETECT_SCHED_HITCNT_EN
        .hit_cnt0 (hit_cnt0),
        .hit_cnt1 (hit_cnt1),
`endif
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // All nine outputs low, as in reset/idle.
    task automatic check_quiet(input string tag);
        check(tag, {23'd0, gnt0, gnt1, shift, det_clr, det_a, hit0, hit1, done, busy}, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    logic s [8];
    int   ng0, ng1, nclr, nsh, ndone, nbusy, idx, nf, ovl, nh;
    logic prev_g;
    int   t_first [4];
    logic o_first [4];

    initial begin
        s = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        // ---------------- reset state ----------------
        do_reset();
        @(negedge clk);
        check_quiet("reset_outputs");
        step();

        // ---------------- single frame, requester 0 ----------------
        ng0 = 0; ng1 = 0; nclr = 0; nsh = 0; ndone = 0; nbusy = 0; idx = 0;
        req0 = 1'b1;
        d1   = 1'b1;  // non-owner data must be ignored
        for (int c = 0; c < 14; c++) begin
            d0 = (idx < 8) ? s[idx] : 1'b0;
            @(negedge clk);
            if (gnt0)    ng0++;
            if (gnt1)    ng1++;
            if (det_clr) nclr++;
            if (shift)   nsh++;
            if (done)    ndone++;
            if (busy)    nbusy++;
            if (c == 1) check("t1_grant_latency", gnt0, 1'b1);
            if (det_clr) check("t1_clear_det_a", det_a, 1'b0);
            if (gnt0 && shift) begin
                check($sformatf("t1_bit%0d", idx), det_a, s[idx]);
                idx++;
            end
            step();
            req0 = 1'b0;
        end
        d1 = 1'b0;
        check("t1_gnt0_cycles", ng0, 9);
        check("t1_gnt1_cycles", ng1, 0);
        check("t1_clr_cycles", nclr, 1);
        check("t1_shift_cycles", nsh, 8);
        check("t1_done_cycles", ndone, 1);
        check("t1_busy_cycles", nbusy, 10);

        // ---------------- request dropped mid-frame ----------------
        nsh = 0; ndone = 0;
        req0 = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (c == 4) req0 = 1'b0;  // STREAM count 2
            d0 = c[0];
            @(negedge clk);
            if (shift && gnt0) nsh++;
            if (done) ndone++;
            step();
        end
        check("t5_shift_cycles", nsh, 8);
        check("t5_done_cycles", ndone, 1);

        // ---------------- reset mid-STREAM ----------------
        // prio is 1 here (last owner was 0).
        req0 = 1'b1;
        step();
        req0 = 1'b0;
        repeat (5) step();
        @(negedge clk);
        check("t4_in_stream", {30'd0, gnt0, shift}, 32'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check_quiet("t4_after_reset");
        ndone = 0; nbusy = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            @(negedge clk);
            if (done) ndone++;
            if (busy) nbusy++;
        end
        check("t4_no_done", ndone, 0);
        check("t4_stays_idle", nbusy, 0);
        // A tie right after reset must favour requester 0.
        req0 = 1'b1;
        req1 = 1'b1;
        step();
        @(negedge clk);
        check("t4_tie_after_reset", {30'd0, gnt0, gnt1}, 32'd2);
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (11) step();
        req1 = 1'b1;
        step();
        req1 = 1'b0;
        @(negedge clk);
        check("t4_req1_only", {30'd0, gnt0, gnt1}, 32'd1);
        repeat (11) step();

        // ---------------- hit attribution, owner 1 ----------------
        req1 = 1'b1;
        for (int c = 0; c < 13; c++) begin
            // y high in CLEAR, STREAM count 0, STREAM count 3 and RELEASE
            y  = (c == 1) || (c == 2) || (c == 5) || (c == 10);
            d0 = 1'b1;
            d1 = 1'b0;
            @(negedge clk);
            check($sformatf("t3_hits_c%0d", c), {30'd0, hit0, hit1},
                  {30'd0, 1'b0, ((c == 5) || (c == 10))});
            step();
            req1 = 1'b0;
        end
        y  = 1'b0;
        d0 = 1'b0;

        // ---------------- contention from reset ----------------
        req0 = 1'b1;
        req1 = 1'b1;
        do_reset();
        nf = 0; ovl = 0; prev_g = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if ((gnt0 || gnt1) && !prev_g && nf < 4) begin
                t_first[nf] = c;
                o_first[nf] = gnt1;
                nf++;
            end
            prev_g = gnt0 || gnt1;
            if (gnt0 && gnt1) ovl++;
            step();
        end
        req0 = 1'b0;
        req1 = 1'b0;
        check("t2_frames_seen", nf, 4);
        check("t2_overlap", ovl, 0);
        check("t2_first_grant_cycle", t_first[0], 1);
        for (int i = 0; i < 4; i++) begin
            if (i < nf) check($sformatf("t2_owner%0d", i), o_first[i], i[0]);
            if (i > 0 && i < nf)
                check($sformatf("t2_period%0d", i), t_first[i] - t_first[i-1], 11);
        end

`ifdef DETECT_SCHED_HITCNT_EN
        // ---------------- saturating hit counter ----------------
        do_reset();
        req0 = 1'b1;
        y    = 1'b1;
        nh   = 0;
        for (int c = 0; c < 1000 && nh < 300; c++) begin
            @(negedge clk);
            if (hit0) begin
                nh++;
                step();
                if (nh == 100) check("t6_cnt_at_100", hit_cnt0, 100);
            end else begin
                step();
            end
        end
        req0 = 1'b0;
        y    = 1'b0;
        check("t6_hits_reached", nh, 300);
        check("t6_hit_cnt0_sat", hit_cnt0, 255);
        check("t6_hit_cnt1_zero", hit_cnt1, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/detect_sched.md
# detect_sched

Round-robin scheduler that shares one serial sequence detector (`lab_06_p1`-style Moore FSM: serial input `a`, output `y`) between two serial bit-stream requesters. It grants the detector to one requester per fixed-length frame and clears the detector before each frame. It steers the owner's bit stream onto the detector input and attributes each detector hit back to the owning requester. It sits between the two stream sources and the detector instance.

## Interface
Parameters:
- `FRAME_LEN`, default 8: bits per granted frame; legal range 2..255.
- `CW`, default `$clog2(FRAME_LEN+1)`: bit-counter width.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0`, `req1`  in  1  frame request from requester 0 / 1.
- `d0`, `d1`  in  1  serial data bit from requester 0 / 1.
- `gnt0`, `gnt1`  out  1  one-hot grant; never both high.
- `shift`  out  1  high when the owner's current bit is consumed this cycle; the owner advances its bit after each edge where its `gnt` and `shift` are both high.
- `det_clr`  out  1  one-cycle clear pulse to the detector (ORed into detector reset).
- `det_a`  out  1  bit driven to detector input `a`.
- `y`  in  1  detector output.
- `hit0`, `hit1`  out  1  detector hit attributed to requester 0 / 1.
- `done`  out  1  one-cycle end-of-frame pulse.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, CLEAR, STREAM, RELEASE. A 1-bit priority pointer `prio` (0 = requester 0 favoured) and an owner register `own` are kept.
- IDLE: all grants low. If `req0|req1`, the FSM latches `own` and goes to CLEAR. If only one request is high, that requester wins. If both are high, `own = prio`. With no request it stays in IDLE.
- CLEAR: `gnt[own]=1`, `det_clr=1`, `det_a=0`, `shift=0`. The bit counter loads 0. Next state is STREAM.
- STREAM: `gnt[own]=1`, `shift=1`, `det_a = own ? d1 : d0`. The counter increments every cycle. On the cycle with count = FRAME_LEN-1, the next state is RELEASE. STREAM lasts exactly FRAME_LEN cycles.
- RELEASE: grants low, `done=1`, `shift=0`, `det_a=0`. Sets `prio = ~own`. Next state is always IDLE.
- Hit attribution: `hit[own] = y` in STREAM cycles with count ≥ 1 and in RELEASE. This window covers the detector's one-cycle Moore lag on each of the FRAME_LEN bits. The other hit output is 0. Both hit outputs are 0 in IDLE and CLEAR.
- Requests are sampled only in IDLE. Deasserting `req` mid-frame does not abort the frame, and the owner must keep supplying bits. Data on the non-owner input is ignored.
- Outside STREAM, `det_a` is forced to 0.

## Timing
- Reset (synchronous, priority over all) puts the FSM in IDLE with `prio=0`, `own=0`, counter 0. Reset values of all outputs: `gnt0=gnt1=shift=det_clr=det_a=hit0=hit1=done=busy=0`.
- If reset is asserted mid-frame, the frame is abandoned, grant drops in the cycle after the reset edge, and no `done` is issued.
- Frame length: with a request present at an IDLE edge, the sequence is CLEAR (1 cycle), then STREAM (FRAME_LEN cycles), then RELEASE (1 cycle), then IDLE (≥1 cycle). The minimum request-to-request period is FRAME_LEN+3 cycles.
- Grant latency is 1 cycle from request sampled in IDLE to `gnt` high in CLEAR. The first bit consumed is `d` during the first STREAM cycle.
- Simultaneous continuous requests alternate owners 0,1,0,1,… starting with 0 after reset.
- All outputs except `det_a` and `hit*` are decoded from registered state only. `det_a` and `hit*` are combinational from `d*`/`y`.

## Configuration
- `DETECT_SCHED_HITCNT_EN`:
  - Defined: adds outputs `hit_cnt0`, `hit_cnt1` (8 bits each). Each is a saturating count of cycles with the corresponding `hit` high; it saturates at 255 and is cleared only by `reset`.
  - Undefined: these ports and counters do not exist, and the rest of the behaviour is identical.

## Test plan
- Single frame: FRAME_LEN=8, `req0` pulsed 1 cycle in IDLE, `d0` stream 1,1,0,1,0,0,1,1. Required: `gnt0` high 9 cycles, `det_clr` 1 cycle, `shift` 8 cycles, `det_a` reproduces the stream, `done` 1 cycle, `gnt1` never high.
- Contention: `req0=req1=1` held continuously from reset. Required: owners 0,1,0,1; each frame is 11 cycles apart; grants are never overlapping.
- Hit attribution: `y` forced high in STREAM count 3 and in RELEASE while `own=1`. Required: `hit1` high in exactly those 2 cycles and `hit0` stays 0; with `y=1` in CLEAR, both hits stay 0.
- Reset mid-STREAM (count 4): required next cycle is IDLE, all outputs 0, no `done`. A subsequent `req1`-only request is granted to requester 1 and `prio` has returned to 0.
- Request drop: `req0` deasserted at STREAM count 2. Required: the frame still completes with 8 `shift` cycles and `done`.
- With `DETECT_SCHED_HITCNT_EN`: 300 hit cycles on requester 0. Required: `hit_cnt0=255` and `hit_cnt1=0`.
